// File: rtl/tdc_theta_calibrator.sv
// Closed-loop TDC theta calibrator: steps the MMCM phase until the averaged thermometer depth sits near TARGET.
// Optional macro TDC_CAL_LEADING_ONES_EN selects bubble-tolerant leading-ones depth instead of popcount.
module tdc_theta_calibrator #(
  parameter int SAMPLES_LOG2  = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int TARGET        = 32,
  parameter int TOL           = 4,
  parameter int MAX_STEPS     = 1023,
  parameter int DONE_TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] tdc_data,
  input  logic        data_valid,
  input  logic        ps_ready,
  output logic        ps_en,
  output logic        ps_incdec,
  input  logic        ps_done,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [15:0] phase_offset,
  output logic [6:0]  depth_avg
);

  localparam int ACC_W  = 7 + SAMPLES_LOG2;
  localparam int SMP_W  = SAMPLES_LOG2 + 1;
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W  = $clog2(DONE_TIMEOUT + 1);

  localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'((1 << SAMPLES_LOG2) - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);
  localparam logic [6:0]        TGT      = 7'(TARGET);
  localparam logic [7:0]        TOL_V    = 8'(TOL);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT_LOCK, ST_SETTLE, ST_MEASURE, ST_DECIDE,
    ST_SHIFT, ST_WAIT_DONE, ST_DONE, ST_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [6:0]        avg_q, avg_d;
  logic [15:0]       phase_q, phase_d;
  logic              incdec_q, incdec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;

  logic [6:0]        depth;
  logic [ACC_W-1:0]  acc_sum;
  logic [6:0]        avg_err;
  logic              within_tol;
  logic              lock_lost;

`ifdef TDC_CAL_LEADING_ONES_EN
  // Depth is the index of the lowest 0, so stray 1s above a bubble are ignored.
  always_comb begin
    depth = 7'd64;
    for (int i = 63; i >= 0; i--) begin
      if (!tdc_data[i]) depth = 7'(i);
    end
  end
`else
  always_comb begin
    depth = '0;
    for (int i = 0; i < 64; i++) begin
      depth = depth + 7'(tdc_data[i]);
    end
  end
`endif

  assign acc_sum    = acc_q + ACC_W'(depth);
  assign avg_err    = (avg_q >= TGT) ? (avg_q - TGT) : (TGT - avg_q);
  assign within_tol = ({1'b0, avg_err} <= TOL_V);
  assign lock_lost  = !ps_ready && (state_q inside {ST_SETTLE, ST_MEASURE, ST_DECIDE,
                                                    ST_SHIFT, ST_WAIT_DONE});

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
    smp_d    = smp_q;
    acc_d    = acc_q;
    tmo_d    = tmo_q;
    avg_d    = avg_q;
    phase_d  = phase_q;
    incdec_d = incdec_q;
    busy_d   = busy_q;
    done_d   = done_q;
    fail_d   = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_LOCK;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          step_d  = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (ps_ready) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = ST_MEASURE;
          acc_d   = '0;
          smp_d   = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (data_valid) begin
          if (smp_q == SMP_LAST) begin
            avg_d   = 7'(acc_sum >> SAMPLES_LOG2);
            state_d = ST_DECIDE;
          end else begin
            acc_d = acc_sum;
            smp_d = smp_q + 1'b1;
          end
        end
      end
      ST_DECIDE: begin
        if (within_tol) begin
          state_d = ST_DONE;
        end else if (step_q == STEP_MAX) begin
          state_d = ST_FAIL;
        end else begin
          state_d  = ST_SHIFT;
          incdec_d = (avg_q < TGT);
        end
      end
      ST_SHIFT: begin
        step_d  = step_q + 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (ps_done) begin
          if (incdec_q) begin
            if (phase_q != 16'h7FFF) phase_d = phase_q + 16'd1;
          end else begin
            if (phase_q != 16'h8000) phase_d = phase_q - 16'd1;
          end
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAIL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (lock_lost) state_d = ST_FAIL;

    // Flags are raised on entry so they are visible the cycle the run terminates.
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
    if (state_d == ST_FAIL) begin
      fail_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      settle_q <= '0;
      smp_q    <= '0;
      acc_q    <= '0;
      tmo_q    <= '0;
      avg_q    <= '0;
      phase_q  <= '0;
      incdec_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      smp_q    <= smp_d;
      acc_q    <= acc_d;
      tmo_q    <= tmo_d;
      avg_q    <= avg_d;
      phase_q  <= phase_d;
      incdec_q <= incdec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  assign ps_en        = (state_q == ST_SHIFT) && ps_ready;
  assign ps_incdec    = incdec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign phase_offset = phase_q;
  assign depth_avg    = avg_q;

endmodule
